// File: rtl/dio_spi_master.sv
// rtl/dio_spi_master.sv - SPI master that streams a menu index and file bytes to a data_io receiver
// Frames are IDX, TXS, DAT (skipped for empty files) and TXE, each closed by an SS2-high gap.
module dio_spi_master #(
  parameter int CLK_DIV = 2,
  parameter int SS_GAP  = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  index,
  input  logic [31:0] length,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        busy,
  output logic        done,
  output logic [7:0]  status,
  output logic        SPI_SCK,
  output logic        SPI_SS2,
  output logic        SPI_DI,
  input  logic        SPI_DO
);

  typedef enum logic [2:0] {S_IDLE, S_FRAME, S_FETCH, S_TAIL, S_GAP, S_DONE} state_t;
  typedef enum logic [1:0] {F_IDX, F_TXS, F_DAT, F_TXE} frame_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(SS_GAP - 1);
  localparam logic [7:0] CMD_IDX  = 8'h55;
  localparam logic [7:0] CMD_TX   = 8'h53;
  localparam logic [7:0] CMD_DAT  = 8'h54;

  state_t      state;
  frame_t      frame;
  logic [7:0]  cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  tx_sr;
  logic [6:0]  rx_sr;
  logic [7:0]  index_q;
  logic [31:0] remaining;
  logic        cmd_byte;

  logic [7:0]  arg_byte;
  logic [7:0]  next_cmd;
  frame_t      next_frame;
  logic        half_end;
  logic        need_byte;

  always_comb begin
    case (frame)
      F_IDX:   arg_byte = index_q;
      F_TXS:   arg_byte = 8'hFF;
      default: arg_byte = 8'h00;
    endcase
    // An empty file goes straight from TXS to TXE.
    if (frame == F_TXS && remaining == 32'd0)
      next_frame = F_TXE;
    else
      next_frame = frame_t'(frame + 2'd1);
    case (next_frame)
      F_IDX:   next_cmd = CMD_IDX;
      F_DAT:   next_cmd = CMD_DAT;
      default: next_cmd = CMD_TX;
    endcase
    half_end  = (cnt == DIV_LAST);
    need_byte = (frame == F_DAT) && (cmd_byte || remaining != 32'd0);
    // Bytes are taken only on a byte boundary, so a stall can never split a byte.
    din_ready = din_valid &&
                ((state == S_FETCH) ||
                 (state == S_FRAME && SPI_SCK && half_end && bit_cnt == 3'd7 && need_byte));
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      frame     <= F_IDX;
      cnt       <= 8'd0;
      bit_cnt   <= 3'd0;
      tx_sr     <= 8'd0;
      rx_sr     <= 7'd0;
      index_q   <= 8'd0;
      remaining <= 32'd0;
      cmd_byte  <= 1'b0;
      status    <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      SPI_SCK   <= 1'b0;
      SPI_SS2   <= 1'b1;
      SPI_DI    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            index_q   <= index;
            remaining <= length;
            frame     <= F_IDX;
            busy      <= 1'b1;
            SPI_SS2   <= 1'b0;
            SPI_DI    <= CMD_IDX[7];
            tx_sr     <= {CMD_IDX[6:0], 1'b0};
            bit_cnt   <= 3'd0;
            cnt       <= 8'd0;
            cmd_byte  <= 1'b1;
            state     <= S_FRAME;
          end
        end

        S_FRAME: begin
          if (!half_end) begin
            cnt <= cnt + 8'd1;
          end else begin
            cnt <= 8'd0;
            if (!SPI_SCK) begin
              SPI_SCK <= 1'b1;
              if (cmd_byte) begin
                rx_sr <= {rx_sr[5:0], SPI_DO};
                if (bit_cnt == 3'd7)
                  status <= {rx_sr, SPI_DO};
              end
            end else begin
              SPI_SCK <= 1'b0;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt != 3'd7) begin
                SPI_DI <= tx_sr[7];
                tx_sr  <= {tx_sr[6:0], 1'b0};
              end else begin
                cmd_byte <= 1'b0;
                if (need_byte) begin
                  if (din_valid) begin
                    SPI_DI    <= din[7];
                    tx_sr     <= {din[6:0], 1'b0};
                    remaining <= remaining - 32'd1;
                  end else begin
                    state <= S_FETCH;
                  end
                end else if (frame != F_DAT && cmd_byte) begin
                  SPI_DI <= arg_byte[7];
                  tx_sr  <= {arg_byte[6:0], 1'b0};
                end else begin
                  state <= S_TAIL;
                end
              end
            end
          end
        end

        S_FETCH: begin
          // SCK is already low and SS2 stays low while the source catches up.
          if (din_valid) begin
            SPI_DI    <= din[7];
            tx_sr     <= {din[6:0], 1'b0};
            remaining <= remaining - 32'd1;
            cnt       <= 8'd0;
            state     <= S_FRAME;
          end
        end

        S_TAIL: begin
          if (half_end) begin
            cnt     <= 8'd0;
            SPI_SS2 <= 1'b1;
            state   <= S_GAP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= 8'd0;
            if (frame == F_TXE) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              frame    <= next_frame;
              SPI_SS2  <= 1'b0;
              SPI_DI   <= next_cmd[7];
              tx_sr    <= {next_cmd[6:0], 1'b0};
              bit_cnt  <= 3'd0;
              cmd_byte <= 1'b1;
              state    <= S_FRAME;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dio_spi_master.sv
// tb/tb_dio_spi_master.sv - randomized bench with a data_io receiver model and frame-level reference
module tb_dio_spi_master;

  localparam int CLK_DIV = 2;
  localparam int SS_GAP  = 4;
  localparam int BUDGET  = 20000;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  index;
  logic [31:0] length;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic        busy;
  logic        done;
  logic [7:0]  status;
  logic        SPI_SCK;
  logic        SPI_SS2;
  logic        SPI_DI;
  logic        SPI_DO;

  dio_spi_master #(.CLK_DIV(CLK_DIV), .SS_GAP(SS_GAP)) dut (
    .clk_sys(clk_sys), .reset(reset), .start(start), .index(index), .length(length),
    .din(din), .din_valid(din_valid), .din_ready(din_ready), .busy(busy), .done(done),
    .status(status), .SPI_SCK(SPI_SCK), .SPI_SS2(SPI_SS2), .SPI_DI(SPI_DI), .SPI_DO(SPI_DO)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Shared between stimulus, file source and receiver
  logic [7:0] src_data [64];
  int         src_gap  [64];
  int         src_len  = 0;
  bit         do_fixed = 1'b0;
  int         ready_total = 0;
  int         done_total  = 0;
  int         frames_in_xfer = 0;
  int         rises_in_frame = 0;
  logic [7:0] got_bytes[$];
  int         got_flen[$];
  int         rd_f = 0;
  int         rd_b = 0;

  // File byte source: random valid gaps between bytes, junk with valid=1 when not wanted
  int src_ptr;
  int wait_cnt;
  always @(negedge clk_sys) begin
    if (reset || !busy) begin
      src_ptr   = 0;
      wait_cnt  = src_gap[0];
      din_valid = 1'b1;
      din       = 8'($urandom);
    end else if (wait_cnt > 0) begin
      wait_cnt--;
      din_valid = 1'b0;
    end else begin
      din_valid = 1'b1;
      din       = (src_ptr < src_len) ? src_data[src_ptr] : 8'($urandom);
    end
    #1;
    if (din_ready) begin
      ready_total++;
      check("ready_in_frame", 32'(SPI_SS2), 32'd0);
      if (busy && src_ptr < 63) begin
        src_ptr++;
        wait_cnt = src_gap[src_ptr];
      end
    end
  end

  // data_io receiver and SPI_DO transmitter model
  bit         prev_sck, prev_ss2;
  int         nbits, hi_len, since_fall, gap_len;
  logic [7:0] cur_byte, cur_st, do_sh;
  logic [7:0] frame_q[$];
  always @(negedge clk_sys) begin
    if (reset) begin
      prev_sck = 1'b0; prev_ss2 = 1'b1; nbits = 0; hi_len = 0; since_fall = 0; gap_len = 0;
      frame_q.delete(); frames_in_xfer = 0; rises_in_frame = 0; SPI_DO = 1'b0;
    end else begin
      if (done) begin done_total++; frames_in_xfer = 0; end
      if (prev_ss2 && !SPI_SS2) begin
        if (frames_in_xfer > 0) check("ss_gap", 32'(gap_len), 32'(SS_GAP));
        cur_st = do_fixed ? 8'h08 : 8'($urandom);
        do_sh  = cur_st;
        SPI_DO = do_sh[7];
        nbits = 0; rises_in_frame = 0; frame_q.delete();
      end
      if (!prev_sck && SPI_SCK) begin
        check("sck_under_ss", 32'(SPI_SS2), 32'd0);
        cur_byte = {cur_byte[6:0], SPI_DI};
        nbits++; rises_in_frame++;
        if (nbits % 8 == 0) frame_q.push_back(cur_byte);
        hi_len = 1;
      end else if (SPI_SCK) begin
        hi_len++;
      end
      if (prev_sck && !SPI_SCK) begin
        check("sck_high", 32'(hi_len), 32'(CLK_DIV));
        since_fall = 1;
        do_sh  = {do_sh[6:0], 1'b0};
        SPI_DO = do_sh[7];
      end else if (!SPI_SS2) begin
        since_fall++;
      end
      if (!prev_ss2 && SPI_SS2) begin
        check("ss_tail", 32'(since_fall), 32'(CLK_DIV));
        check("frame_bits", 32'(nbits % 8), 32'd0);
        check("status", 32'(status), 32'(cur_st));
        got_flen.push_back(frame_q.size());
        foreach (frame_q[i]) got_bytes.push_back(frame_q[i]);
        frames_in_xfer++;
        gap_len = 1;
      end else if (SPI_SS2) begin
        gap_len++;
      end
      prev_sck = SPI_SCK;
      prev_ss2 = SPI_SS2;
    end
  end

  task automatic prep_random(input int len);
    src_len = len;
    for (int k = 0; k < 64; k++) begin
      src_data[k] = 8'($urandom);
      src_gap[k]  = $urandom_range(0, 3);
    end
  endtask

  task automatic prep_v1();
    prep_random(3);
    for (int k = 0; k < 64; k++) src_gap[k] = 0;
    src_data[0] = 8'hA5; src_data[1] = 8'h5A; src_data[2] = 8'hFF;
  endtask

  task automatic run_xfer(input logic [7:0] idx, input int len, input bit poke_busy, input bit poke_done);
    int r0, d0, t, gl;
    logic [7:0] ef[$];
    r0 = ready_total; d0 = done_total;
    index = idx; length = 32'(len); start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0; index = 8'($urandom); length = $urandom;
    check("busy_set", 32'(busy), 32'd1);
    t = 0;
    while (done !== 1'b1 && t < BUDGET) begin
      @(negedge clk_sys);
      t++;
      start = (poke_busy && t == 25) ? 1'b1 : 1'b0;
    end
    check("done_seen", 32'(t < BUDGET), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    if (poke_done) start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    repeat (3 * SS_GAP + 8 * CLK_DIV + 10) @(negedge clk_sys);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_ss2", 32'(SPI_SS2), 32'd1);
    check("done_count", 32'(done_total - d0), 32'd1);
    check("ready_count", 32'(ready_total - r0), 32'(len));
    check("frame_count", 32'(got_flen.size() - rd_f), (len > 0) ? 32'd4 : 32'd3);
    for (int f = 0; f < 4; f++) begin
      if (f == 2 && len == 0) continue;
      ef.delete();
      case (f)
        0: begin ef.push_back(8'h55); ef.push_back(idx); end
        1: begin ef.push_back(8'h53); ef.push_back(8'hFF); end
        2: begin ef.push_back(8'h54); for (int k = 0; k < len; k++) ef.push_back(src_data[k]); end
        default: begin ef.push_back(8'h53); ef.push_back(8'h00); end
      endcase
      if (rd_f < got_flen.size()) begin
        gl = got_flen[rd_f];
        check("frame_len", 32'(gl), 32'(ef.size()));
        for (int k = 0; k < gl && k < ef.size(); k++)
          if (rd_b + k < got_bytes.size()) check("frame_byte", 32'(got_bytes[rd_b + k]), 32'(ef[k]));
        rd_b += gl;
        rd_f++;
      end
    end
    rd_f = got_flen.size();
    rd_b = got_bytes.size();
  endtask

  task automatic reset_mid();
    int t;
    prep_random(4);
    index = 8'h3C; length = 32'd4; start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    t = 0;
    while (!(frames_in_xfer == 2 && rises_in_frame == 13) && t < BUDGET) begin
      @(negedge clk_sys);
      t++;
    end
    check("reach_13_rises", 32'(t < BUDGET), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_ss2", 32'(SPI_SS2), 32'd1);
    check("abort_sck", 32'(SPI_SCK), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_status", 32'(status), 32'd0);
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    repeat (20) @(negedge clk_sys);
    check("post_abort_idle", 32'(SPI_SS2), 32'd1);
    rd_f = got_flen.size();
    rd_b = got_bytes.size();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; index = 8'h00; length = 32'd0;
    for (int k = 0; k < 64; k++) begin src_data[k] = 8'h00; src_gap[k] = 0; end
    repeat (3) @(negedge clk_sys);
    check("rst_ss2", 32'(SPI_SS2), 32'd1);
    check("rst_sck", 32'(SPI_SCK), 32'd0);
    check("rst_di", 32'(SPI_DI), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    check("rst_ready", 32'(din_ready), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);

    prep_v1();
    run_xfer(8'h01, 3, 1'b0, 1'b0);

    prep_random(0);
    run_xfer(8'($urandom), 0, 1'b0, 1'b0);

    prep_random(4);
    src_gap[2] = 20;
    run_xfer(8'($urandom), 4, 1'b0, 1'b0);

    do_fixed = 1'b1;
    prep_random(2);
    run_xfer(8'($urandom), 2, 1'b0, 1'b0);
    check("status_fixed", 32'(status), 32'h08);
    do_fixed = 1'b0;

    prep_random(3);
    run_xfer(8'($urandom), 3, 1'b1, 1'b1);

    repeat (6) begin
      int len;
      len = $urandom_range(0, 12);
      prep_random(len);
      run_xfer(8'($urandom), len, 1'b0, 1'b0);
    end

    reset_mid();
    prep_v1();
    run_xfer(8'h01, 3, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
